// File: rtl/blackjack_pkg.sv
// Shared definitions for the blackjack round sequencer and its datapath.
package blackjack_pkg;

    localparam int TOTAL_W_DEF      = 8;
    localparam int BUST_LIMIT_DEF   = 21;
    localparam int DEALER_STAND_DEF = 17;
    localparam int MAX_CARDS_DEF    = 5;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_DEAL_P1     = 4'd1,
        ST_DEAL_D1     = 4'd2,
        ST_DEAL_P2     = 4'd3,
        ST_DEAL_D2     = 4'd4,
        ST_CHK_NAT     = 4'd5,
        ST_PLAYER_TURN = 4'd6,
        ST_P_HIT       = 4'd7,
        ST_P_CHECK     = 4'd8,
        ST_D_CHECK     = 4'd9,
        ST_D_HIT       = 4'd10,
        ST_SETTLE      = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        OUT_NONE = 2'd0,
        OUT_WIN  = 2'd1,
        OUT_LOSE = 2'd2,
        OUT_PUSH = 2'd3
    } outcome_t;

endpackage

// File: rtl/switch_edge.sv
// Rising-edge detector for one switch level. The history flop keeps tracking
// the input through reset, so a switch already high at reset release gives no event.
module switch_edge (
    input  logic clk,
    input  logic sw_i,
    output logic rise_o
);

    logic sw_q;

    // Previous-cycle copy of the switch level.
    always_ff @(posedge clk) begin
        sw_q <= sw_i;
    end

    assign rise_o = sw_i & ~sw_q;

endmodule

// File: rtl/round_scheduler.sv
// Sequences one blackjack round: deal P,D,P,D, player turn, dealer turn, settle.
//
//   state          | meaning
//   ---------------+--------------------------------------------------
//   ST_IDLE        | waiting for go; bet checked against bankroll
//   ST_DEAL_P1..D2 | the four opening draws, player/dealer alternating
//   ST_CHK_NAT     | player 21 after the deal skips the player turn
//   ST_PLAYER_TURN | hold = stand, go = hit, card cap forces stand
//   ST_P_HIT       | player draw
//   ST_P_CHECK     | player bust goes straight to settle
//   ST_D_CHECK     | dealer draws below the stand value and under the cap
//   ST_D_HIT       | dealer draw
//   ST_SETTLE      | one of win/lose/push, then back to idle
//
// Check states wait while a load strobe is out so the datapath totals they
// read already include the card just drawn.
module round_scheduler
    import blackjack_pkg::*;
#(
    parameter int TOTAL_W      = TOTAL_W_DEF,
    parameter int BUST_LIMIT   = BUST_LIMIT_DEF,
    parameter int DEALER_STAND = DEALER_STAND_DEF,
    parameter int MAX_CARDS    = MAX_CARDS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic               hold,
    input  logic [3:0]         bet,
    input  logic [TOTAL_W-1:0] money,
    input  logic [TOTAL_W-1:0] player_total,
    input  logic [TOTAL_W-1:0] dealer_total,
    output logic               draw_req,
    input  logic               card_valid,
    input  logic [3:0]         card_in,
    output logic [3:0]         card_out,
    output logic               ld_card_player,
    output logic               ld_card_dealer,
    output logic               clr_hands,
    output logic               win,
    output logic               lose,
    output logic               push,
    output logic               bet_err,
    output logic [3:0]         state
);

    localparam logic [TOTAL_W-1:0] BUST_T   = TOTAL_W'(BUST_LIMIT);
    localparam logic [TOTAL_W-1:0] STAND_T  = TOTAL_W'(DEALER_STAND);
    localparam logic [2:0]         CARD_CAP = 3'(MAX_CARDS);

    state_t             state_q, state_d;
    outcome_t           outcome_d;
    logic               go_e, hold_e;
    logic               ld_p_q, ld_p_d, ld_d_q, ld_d_d;
    logic               clr_q, clr_d, bet_err_q, bet_err_d;
    logic               win_q, lose_q, push_q;
    logic [3:0]         card_q;
    logic [2:0]         p_cnt_q, d_cnt_q;
    logic [TOTAL_W-1:0] bet_ext;
    logic               in_draw, ld_busy, accept, bet_ok;

    switch_edge u_go_edge   (.clk(clk), .sw_i(go),   .rise_o(go_e));
    switch_edge u_hold_edge (.clk(clk), .sw_i(hold), .rise_o(hold_e));

    assign bet_ext  = TOTAL_W'(bet);
    assign bet_ok   = (bet != 4'd0) && (bet_ext <= money);
    assign in_draw  = state_q inside {ST_DEAL_P1, ST_DEAL_D1, ST_DEAL_P2, ST_DEAL_D2,
                                      ST_P_HIT, ST_D_HIT};
    // The load cycle drops the request, so back-to-back deal states see a gap.
    assign ld_busy  = ld_p_q | ld_d_q;
    assign draw_req = in_draw & ~ld_busy;
    assign accept   = draw_req & card_valid;

    // Next-state and strobe decode.
    always_comb begin
        state_d   = state_q;
        ld_p_d    = 1'b0;
        ld_d_d    = 1'b0;
        clr_d     = 1'b0;
        bet_err_d = 1'b0;
        outcome_d = OUT_NONE;
        case (state_q)
            ST_IDLE: begin
                if (go_e) begin
                    if (bet_ok) begin
                        clr_d   = 1'b1;
                        state_d = ST_DEAL_P1;
                    end else begin
                        bet_err_d = 1'b1;
                    end
                end
            end
            ST_DEAL_P1: if (accept) begin ld_p_d = 1'b1; state_d = ST_DEAL_D1; end
            ST_DEAL_D1: if (accept) begin ld_d_d = 1'b1; state_d = ST_DEAL_P2; end
            ST_DEAL_P2: if (accept) begin ld_p_d = 1'b1; state_d = ST_DEAL_D2; end
            ST_DEAL_D2: if (accept) begin ld_d_d = 1'b1; state_d = ST_CHK_NAT; end
            ST_CHK_NAT: begin
                if (!ld_busy)
                    state_d = (player_total == BUST_T) ? ST_D_CHECK : ST_PLAYER_TURN;
            end
            ST_PLAYER_TURN: begin
                if (hold_e || p_cnt_q == CARD_CAP) state_d = ST_D_CHECK;
                else if (go_e)                     state_d = ST_P_HIT;
            end
            ST_P_HIT: if (accept) begin ld_p_d = 1'b1; state_d = ST_P_CHECK; end
            ST_P_CHECK: begin
                if (!ld_busy)
                    state_d = (player_total > BUST_T) ? ST_SETTLE : ST_PLAYER_TURN;
            end
            ST_D_CHECK: begin
                if (!ld_busy)
                    state_d = (dealer_total < STAND_T && d_cnt_q < CARD_CAP) ? ST_D_HIT
                                                                              : ST_SETTLE;
            end
            ST_D_HIT: if (accept) begin ld_d_d = 1'b1; state_d = ST_D_CHECK; end
            ST_SETTLE: begin
                state_d = ST_IDLE;
                if (player_total > BUST_T)            outcome_d = OUT_LOSE;
                else if (dealer_total > BUST_T)       outcome_d = OUT_WIN;
                else if (player_total > dealer_total) outcome_d = OUT_WIN;
                else if (player_total == dealer_total) outcome_d = OUT_PUSH;
                else                                  outcome_d = OUT_LOSE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and registered output strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            card_q    <= 4'd0;
            ld_p_q    <= 1'b0;
            ld_d_q    <= 1'b0;
            clr_q     <= 1'b0;
            bet_err_q <= 1'b0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            push_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            if (accept) card_q <= card_in;
            ld_p_q    <= ld_p_d;
            ld_d_q    <= ld_d_d;
            clr_q     <= clr_d;
            bet_err_q <= bet_err_d;
            win_q     <= (outcome_d == OUT_WIN);
            lose_q    <= (outcome_d == OUT_LOSE);
            push_q    <= (outcome_d == OUT_PUSH);
        end
    end

    // Per-hand card counters, cleared at round start and saturating at the cap.
    always_ff @(posedge clk) begin
        if (reset || clr_d) begin
            p_cnt_q <= 3'd0;
            d_cnt_q <= 3'd0;
        end else begin
            if (ld_p_d && p_cnt_q < CARD_CAP) p_cnt_q <= p_cnt_q + 3'd1;
            if (ld_d_d && d_cnt_q < CARD_CAP) d_cnt_q <= d_cnt_q + 3'd1;
        end
    end

    assign card_out       = card_q;
    assign ld_card_player = ld_p_q;
    assign ld_card_dealer = ld_d_q;
    assign clr_hands      = clr_q;
    assign bet_err        = bet_err_q;
    assign win            = win_q;
    assign lose           = lose_q;
    assign push           = push_q;
    assign state          = state_q;

endmodule

// File: tb/tb_round_scheduler.sv
// Bench for round_scheduler: acts as card source, switches and totals datapath,
// and compares the observed event stream of each round with a round-level model.
module tb_round_scheduler;
    import blackjack_pkg::*;

    localparam int EV_CLR = 1, EV_P = 2, EV_D = 3, EV_WIN = 4, EV_LOSE = 5,
                   EV_PUSH = 6, EV_ERR = 7;

    logic       clk = 1'b0;
    logic       reset, go, hold, card_valid;
    logic [3:0] bet, card_in, card_out, state;
    logic [7:0] money, player_total, dealer_total;
    logic       draw_req, ld_card_player, ld_card_dealer, clr_hands;
    logic       win, lose, push, bet_err;

    logic [7:0] psum_dp, dsum_dp;
    int         p_ovr = -1;
    int         deck[$];
    int         decs[$];
    int         exp_ev[$];
    int         got_ev[$];
    bit         round_end;
    int         multi_strobe = 0;
    int         n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    round_scheduler dut (
        .clk(clk), .reset(reset), .go(go), .hold(hold), .bet(bet), .money(money),
        .player_total(player_total), .dealer_total(dealer_total),
        .draw_req(draw_req), .card_valid(card_valid), .card_in(card_in),
        .card_out(card_out), .ld_card_player(ld_card_player),
        .ld_card_dealer(ld_card_dealer), .clr_hands(clr_hands),
        .win(win), .lose(lose), .push(push), .bet_err(bet_err), .state(state)
    );

    // Registered totals datapath; an override forces the player total.
    always @(posedge clk) begin
        if (reset || clr_hands) begin
            psum_dp <= 8'd0;
            dsum_dp <= 8'd0;
        end else begin
            if (ld_card_player) psum_dp <= psum_dp + {4'd0, card_out};
            if (ld_card_dealer) dsum_dp <= dsum_dp + {4'd0, card_out};
        end
    end
    assign player_total = (p_ovr >= 0) ? p_ovr[7:0] : psum_dp;
    assign dealer_total = dsum_dp;

    // Event monitor.
    always @(negedge clk) begin
        if ((int'(win) + int'(lose) + int'(push) + int'(bet_err)) > 1) multi_strobe++;
        if (ld_card_player && ld_card_dealer) multi_strobe++;
        if (clr_hands)      got_ev.push_back(EV_CLR * 16);
        if (ld_card_player) got_ev.push_back(EV_P * 16 + int'(card_out));
        if (ld_card_dealer) got_ev.push_back(EV_D * 16 + int'(card_out));
        if (win)            got_ev.push_back(EV_WIN * 16);
        if (lose)           got_ev.push_back(EV_LOSE * 16);
        if (push)           got_ev.push_back(EV_PUSH * 16);
        if (bet_err)        got_ev.push_back(EV_ERR * 16);
        if (win || lose || push || bet_err) round_end = 1'b1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int card_at(input int i);
        return (i < deck.size()) ? deck[i] : 5;
    endfunction

    // Round model: blackjack rules over hand sums, decisions 0=hit 1=stand 2=both.
    task automatic build_expected(input int bet_v, input int money_v);
        int ci, di, ps, ds, pn, dn, pt, k;
        bit bust, stand;
        exp_ev.delete();
        if (bet_v == 0 || bet_v > money_v) begin
            exp_ev.push_back(EV_ERR * 16);
            return;
        end
        exp_ev.push_back(EV_CLR * 16);
        ci = 0; di = 0; ps = 0; ds = 0; pn = 0; dn = 0;
        repeat (2) begin
            ps += card_at(ci); pn++; exp_ev.push_back(EV_P * 16 + card_at(ci)); ci++;
            ds += card_at(ci); dn++; exp_ev.push_back(EV_D * 16 + card_at(ci)); ci++;
        end
        pt = (p_ovr >= 0) ? p_ovr : ps;
        bust = 1'b0;
        stand = (pt == 21);
        while (!stand && !bust) begin
            if (pn >= 5) stand = 1'b1;
            else begin
                k = (di < decs.size()) ? decs[di] : 1;
                di++;
                if (k != 0) stand = 1'b1;
                else begin
                    ps += card_at(ci); pn++;
                    exp_ev.push_back(EV_P * 16 + card_at(ci)); ci++;
                    pt = (p_ovr >= 0) ? p_ovr : ps;
                    bust = (pt > 21);
                end
            end
        end
        if (!bust)
            while (ds < 17 && dn < 5) begin
                ds += card_at(ci); dn++;
                exp_ev.push_back(EV_D * 16 + card_at(ci)); ci++;
            end
        if (bust)           exp_ev.push_back(EV_LOSE * 16);
        else if (ds > 21)   exp_ev.push_back(EV_WIN * 16);
        else if (pt > ds)   exp_ev.push_back(EV_WIN * 16);
        else if (pt == ds)  exp_ev.push_back(EV_PUSH * 16);
        else                exp_ev.push_back(EV_LOSE * 16);
    endtask

    task automatic compare_events(input string tag);
        chk({tag, "_nev"}, got_ev.size(), exp_ev.size());
        for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++)
            chk($sformatf("%s_ev%0d", tag, i), got_ev[i], exp_ev[i]);
    endtask

    task automatic run_round(input string tag, input int bet_v, input int money_v,
                             input bit fixed_dly);
        int ci, di, budget, k, len, dly;
        build_expected(bet_v, money_v);
        got_ev.delete();
        round_end = 1'b0;
        bet = bet_v[3:0];
        money = money_v[7:0];
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        ci = 0; di = 0; budget = 0;
        while (!round_end && budget < 500) begin
            @(negedge clk); budget++;
            card_valid = 1'b0;
            if (draw_req) begin
                dly = fixed_dly ? ((ci % 2) != 0 ? 3 : 0) : int'($urandom_range(0, 3));
                repeat (dly) begin @(negedge clk); budget++; end
                card_valid = 1'b1;
                card_in = 4'(card_at(ci));
                ci++;
            end else if (state == ST_PLAYER_TURN) begin
                k = (di < decs.size()) ? decs[di] : 1;
                di++;
                go = (k != 1);
                hold = (k != 0);
                len = $urandom_range(1, 3);
                repeat (len) begin @(negedge clk); budget++; end
                go = 1'b0;
                hold = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                card_valid = 1'b1;
                card_in = 4'($urandom_range(1, 10));
            end
        end
        card_valid = 1'b0;
        chk({tag, "_done"}, int'(round_end), 1);
        repeat (3) @(negedge clk);
        chk({tag, "_idle"}, int'(state), int'(ST_IDLE));
        compare_events(tag);
    endtask

    task automatic wait_draw(input string tag);
        int t = 0;
        while (!draw_req && t < 50) begin @(negedge clk); t++; end
        chk({tag, "_draw_req"}, int'(draw_req), 1);
    endtask

    initial begin
        reset = 1'b1; go = 1'b1; hold = 1'b0; card_valid = 1'b0; card_in = 4'd0;
        bet = 4'd3; money = 8'd10;

        // Reset with go held high: idle, quiet outputs, no start event.
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_state", int'(state), int'(ST_IDLE));
        chk("rst_outputs", int'({draw_req, card_out, ld_card_player, ld_card_dealer,
                                 clr_hands, win, lose, push, bet_err}), 0);
        got_ev.delete();
        repeat (4) @(negedge clk);
        chk("rst_go_held_nev", got_ev.size(), 0);
        chk("rst_go_held_state", int'(state), int'(ST_IDLE));
        go = 1'b0;
        @(negedge clk);

        // Bet checks.
        deck = {4, 10, 7, 6, 1, 1, 1}; decs = {1};
        run_round("bet_over", 6, 5, 1'b0);
        run_round("bet_zero", 0, 5, 1'b0);
        // Deal order with alternating 0/3 cycle card delays; player stands 11, dealer 16->17.
        run_round("deal_order", 3, 5, 1'b1);

        // Dealer play.
        deck = {10, 10, 8, 6, 1}; decs = {1};
        run_round("dealer_17_win", 2, 9, 1'b0);
        deck = {10, 10, 8, 8, 1}; decs = {1};
        run_round("dealer_push", 2, 9, 1'b0);
        deck = {10, 10, 8, 6, 7}; decs = {1};
        run_round("dealer_bust", 2, 9, 1'b0);
        deck = {10, 10, 8, 6, 1}; decs = {2};
        run_round("go_hold_same", 2, 9, 1'b0);

        // Player bust forced through the totals bus: no dealer draws.
        p_ovr = 25;
        deck = {5, 10, 6, 6, 10, 3}; decs = {0};
        run_round("player_bust", 2, 9, 1'b0);
        // Player 21 after the deal skips the player turn.
        p_ovr = 21;
        deck = {10, 10, 8, 6, 1}; decs = {0, 0};
        run_round("natural", 2, 9, 1'b0);
        p_ovr = -1;

        // Player card cap forces the stand; dealer card cap stops dealer draws.
        deck = {1, 10, 1, 6, 1, 1, 1, 1, 1}; decs = {0, 0, 0, 0, 0};
        run_round("player_cap", 2, 9, 1'b0);
        deck = {1, 1, 1, 1, 1, 1, 1, 1, 1}; decs = {1};
        run_round("dealer_cap", 2, 9, 1'b0);

        // Reset while a draw is pending abandons the round without a settle strobe.
        deck = {3, 4, 5, 6};
        exp_ev = {EV_CLR * 16, EV_P * 16 + 3};
        got_ev.delete();
        bet = 4'd2; money = 8'd9;
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        wait_draw("mid_rst_p1");
        card_valid = 1'b1; card_in = 4'd3;
        @(negedge clk); card_valid = 1'b0;
        @(negedge clk);
        wait_draw("mid_rst_d1");
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("mid_rst_state", int'(state), int'(ST_IDLE));
        chk("mid_rst_draw_req", int'(draw_req), 0);
        repeat (5) @(negedge clk);
        compare_events("mid_rst");

        // Randomized rounds.
        for (int r = 0; r < 30; r++) begin
            deck.delete();
            decs.delete();
            for (int i = 0; i < 12; i++) deck.push_back(int'($urandom_range(1, 10)));
            for (int i = 0; i < 6; i++) begin
                int v;
                v = $urandom_range(0, 9);
                decs.push_back(v < 5 ? 0 : (v < 8 ? 1 : 2));
            end
            run_round($sformatf("rnd%0d", r), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 20)), 1'b0);
        end

        chk("strobe_exclusive", multi_strobe, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
